// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker feeding the decode-stage stall input.
// Optional HAZARD_STATS_EN adds free-running stall_cycles / issue_count counters.
module hazard_scoreboard #(
    parameter int NREG    = 16,
    parameter int CNT_W   = 2,
    parameter int TIMEOUT = 64,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic [IDX_W-1:0] id_dest,
    input  logic [IDX_W-1:0] id_src1,
    input  logic [IDX_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             wb_wb_en,
    input  logic [IDX_W-1:0] wb_dest,
    output logic             hazard,
    output logic [NREG-1:0]  busy_mask,
    output logic             sb_error,
`ifdef HAZARD_STATS_EN
    output logic             deadlock,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      issue_count
`else
    output logic             deadlock
`endif
);

    localparam int ST_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q   [NREG];
    logic [CNT_W-1:0] cnt_d   [NREG];
    logic [CNT_W-1:0] eff_cnt [NREG];
    logic [NREG-1:0]  retire_hit;
    logic [NREG-1:0]  issue_hit;
    logic [NREG-1:0]  underflow;
    logic             src1_busy;
    logic             src2_busy;
    logic             dest_full;
    logic             issue;
    logic [ST_W-1:0]  stall_q, stall_d;
    logic             sb_error_q, sb_error_d;
    logic             deadlock_q, deadlock_d;

    // eff_cnt folds in this cycle's retire so a same-cycle writeback releases the stall.
    // A retire against an empty counter is flagged and otherwise ignored.
    always_comb begin
        retire_hit = '0;
        underflow  = '0;
        for (int r = 0; r < NREG; r++) begin
            retire_hit[r] = wb_wb_en && (wb_dest == IDX_W'(r));
            underflow[r]  = retire_hit[r] && (cnt_q[r] == '0);
            if (retire_hit[r] && (cnt_q[r] != '0)) begin
                eff_cnt[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                eff_cnt[r] = cnt_q[r];
            end
        end
    end

    // A full destination counter stalls the issue instead of overflowing it.
    always_comb begin
        src1_busy = (eff_cnt[id_src1] != '0);
        src2_busy = id_two_src && (eff_cnt[id_src2] != '0);
        dest_full = id_wb_en && (eff_cnt[id_dest] == CNT_MAX);
        hazard    = id_valid && !flush && (src1_busy || src2_busy || dest_full);
        issue     = id_valid && id_wb_en && !hazard && !freeze && !flush;
    end

    always_comb begin
        issue_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            issue_hit[r] = issue && (id_dest == IDX_W'(r));
            cnt_d[r]     = eff_cnt[r] + CNT_W'(issue_hit[r]);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // Stall-run counter holds while frozen and saturates at TIMEOUT.
    always_comb begin
        stall_d = stall_q;
        if (!hazard) begin
            stall_d = '0;
        end else if (!freeze && (stall_q != ST_W'(TIMEOUT))) begin
            stall_d = stall_q + ST_W'(1);
        end
        deadlock_d = deadlock_q || (stall_d == ST_W'(TIMEOUT));
        sb_error_d = sb_error_q || (|underflow);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_q    <= '0;
            sb_error_q <= 1'b0;
            deadlock_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_q    <= stall_d;
            sb_error_q <= sb_error_d;
            deadlock_q <= deadlock_d;
        end
    end

    assign sb_error = sb_error_q;
    assign deadlock = deadlock_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] issue_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            issue_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + 32'(hazard);
            issue_count_q  <= issue_count_q + 32'(issue);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign issue_count  = issue_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario-driven bench for hazard_scoreboard: expected outputs are queued as
// stimulus is applied and compared against the DUT at the following falling edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze, flush, id_valid, id_wb_en, id_two_src, wb_wb_en;
    logic [3:0]  id_dest, id_src1, id_src2, wb_dest;
    logic        hazard, sb_error, deadlock;
    logic [15:0] busy_mask;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, issue_count;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_wb_en     (id_wb_en),
        .id_dest      (id_dest),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .wb_wb_en     (wb_wb_en),
        .wb_dest      (wb_dest),
        .hazard       (hazard),
        .busy_mask    (busy_mask),
        .sb_error     (sb_error),
`ifdef HAZARD_STATS_EN
        .deadlock     (deadlock),
        .stall_cycles (stall_cycles),
        .issue_count  (issue_count)
`else
        .deadlock     (deadlock)
`endif
    );

    typedef struct {
        string       tag;
        logic [18:0] v;   // {hazard, busy_mask, sb_error, deadlock}
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string tag, input logic hz, input logic [15:0] busy,
                            input logic err, input logic dl);
        exp_t e;
        e.tag = tag;
        e.v   = {hz, busy, err, dl};
        sb_q.push_back(e);
    endtask

    task automatic drv(input logic v, input logic we, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic two,
                       input logic wbe, input logic [3:0] wbd);
        id_valid   = v;
        id_wb_en   = we;
        id_dest    = d;
        id_src1    = s1;
        id_src2    = s2;
        id_two_src = two;
        wb_wb_en   = wbe;
        wb_dest    = wbd;
        freeze     = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            case (i)
                0: begin rst = 1'b0; idle(); push_exp("rst_hold", 1'b0, 16'h0, 1'b0, 1'b0); end
                default: begin rst = 1'b1; idle(); push_exp("rst_release", 1'b0, 16'h0, 1'b0, 1'b0); end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_raw();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            case (i)
                0: begin drv(1, 1, 4'd3, 4'd0, 4'd0, 0, 0, 4'd0); push_exp("raw_issue", 0, 16'h0000, 0, 0); end
                1: begin drv(1, 0, 4'd0, 4'd3, 4'd0, 0, 0, 4'd0); push_exp("raw_stall", 1, 16'h0008, 0, 0); end
                2: begin drv(1, 0, 4'd0, 4'd3, 4'd0, 0, 1, 4'd3); push_exp("raw_wb_release", 0, 16'h0008, 0, 0); end
                default: begin idle(); push_exp("raw_idle", 0, 16'h0000, 0, 0); end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_issue_retire_same();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            case (i)
                0: begin drv(1, 1, 4'd5, 4'd0, 4'd0, 0, 0, 4'd0); push_exp("same_first_issue", 0, 16'h0000, 0, 0); end
                1: begin drv(1, 1, 4'd5, 4'd0, 4'd0, 0, 1, 4'd5); push_exp("same_issue_retire", 0, 16'h0020, 0, 0); end
                2: begin idle(); push_exp("same_cnt_held", 0, 16'h0020, 0, 0); end
                3: begin drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd5); push_exp("same_last_retire", 0, 16'h0020, 0, 0); end
                default: begin idle(); push_exp("same_drained", 0, 16'h0000, 0, 0); end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_two_src();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            next_cyc();
            case (i)
                0: begin drv(1, 1, 4'd7, 4'd0, 4'd0, 0, 0, 4'd0); push_exp("src2_issue", 0, 16'h0000, 0, 0); end
                1: begin drv(1, 0, 4'd0, 4'd0, 4'd7, 0, 0, 4'd0); push_exp("src2_unused", 0, 16'h0080, 0, 0); end
                2: begin drv(1, 0, 4'd0, 4'd0, 4'd7, 1, 0, 4'd0); push_exp("src2_used", 1, 16'h0080, 0, 0); end
                3: begin drv(0, 0, 4'd0, 4'd0, 4'd7, 1, 0, 4'd0); push_exp("src2_invalid_gate", 0, 16'h0080, 0, 0); end
                4: begin drv(1, 0, 4'd0, 4'd0, 4'd7, 1, 0, 4'd0); flush = 1'b1;
                         push_exp("src2_flush_gate", 0, 16'h0080, 0, 0); end
                5: begin drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd7); push_exp("src2_retire", 0, 16'h0080, 0, 0); end
                default: begin idle(); push_exp("src2_drained", 0, 16'h0000, 0, 0); end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            next_cyc();
            if (i < 3) begin
                drv(1, 1, 4'd2, 4'd0, 4'd0, 0, 0, 4'd0);
                push_exp("ovf_fill", 0, (i == 0) ? 16'h0000 : 16'h0004, 0, 0);
            end else if (i == 3) begin
                drv(1, 1, 4'd2, 4'd0, 4'd0, 0, 0, 4'd0);
                push_exp("ovf_block", 1, 16'h0004, 0, 0);
            end else if (i == 4) begin
                drv(1, 1, 4'd2, 4'd0, 4'd0, 0, 1, 4'd2);
                push_exp("ovf_issue_with_retire", 0, 16'h0004, 0, 0);
            end else if (i < 8) begin
                drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd2);
                push_exp("ovf_drain", 0, 16'h0004, 0, 0);
            end else begin
                idle();
                push_exp("ovf_empty", 0, 16'h0000, 0, 0);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_underflow_flush();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            next_cyc();
            case (i)
                0: begin drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd9); push_exp("unf_retire_empty", 0, 16'h0000, 0, 0); end
                1: begin drv(1, 1, 4'd9, 4'd0, 4'd0, 0, 0, 4'd0); push_exp("unf_err_set", 0, 16'h0000, 1, 0); end
                2: begin idle(); push_exp("unf_cnt_was_zero", 0, 16'h0200, 1, 0); end
                3: begin drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd9); push_exp("unf_normal_retire", 0, 16'h0200, 1, 0); end
                4: begin idle(); push_exp("unf_drained", 0, 16'h0000, 1, 0); end
                5: begin drv(1, 1, 4'd4, 4'd0, 4'd0, 0, 0, 4'd0); flush = 1'b1;
                         push_exp("flush_issue", 0, 16'h0000, 1, 0); end
                6: begin idle(); push_exp("flush_no_count", 0, 16'h0000, 1, 0); end
                7: begin drv(1, 1, 4'd4, 4'd0, 4'd0, 0, 0, 4'd0); freeze = 1'b1;
                         push_exp("freeze_issue", 0, 16'h0000, 1, 0); end
                default: begin idle(); push_exp("freeze_no_count", 0, 16'h0000, 1, 0); end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_deadlock_reset();
        exp_t e;
        for (int i = 0; i < 72; i++) begin
            next_cyc();
            if (i == 0) begin
                drv(1, 1, 4'd11, 4'd0, 4'd0, 0, 0, 4'd0);
                push_exp("dl_issue", 0, 16'h0000, 1, 0);
            end else if (i <= 65) begin
                drv(1, 0, 4'd0, 4'd11, 4'd0, 0, 0, 4'd0);
                push_exp((i >= 65) ? "dl_flagged" : "dl_stall_run", 1, 16'h0800, 1, (i >= 65));
            end else if (i == 66) begin
                drv(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd11);
                push_exp("dl_sticky_retire", 0, 16'h0800, 1, 1);
            end else if (i == 67) begin
                idle();
                push_exp("dl_sticky_idle", 0, 16'h0000, 1, 1);
            end else if (i == 68) begin
                drv(1, 1, 4'd1, 4'd0, 4'd0, 0, 0, 4'd0);
                push_exp("mid_issue", 0, 16'h0000, 1, 1);
            end else if (i == 69) begin
                drv(1, 0, 4'd0, 4'd1, 4'd0, 0, 0, 4'd0);
                push_exp("mid_stall", 1, 16'h0002, 1, 1);
            end else if (i == 70) begin
                rst = 1'b0;
                drv(1, 0, 4'd0, 4'd1, 4'd0, 0, 0, 4'd0);
                push_exp("mid_rst_asserted", 1, 16'h0002, 1, 1);
            end else begin
                rst = 1'b1;
                drv(1, 0, 4'd0, 4'd1, 4'd0, 0, 0, 4'd0);
                push_exp("mid_rst_cleared", 0, 16'h0000, 0, 0);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({hazard, busy_mask, sb_error, deadlock} !== e.v) begin
                errors++;
                $display("FAIL %s: got hz/busy/err/dl=%b/%h/%b/%b want %b/%h/%b/%b", e.tag,
                         hazard, busy_mask, sb_error, deadlock, e.v[18], e.v[17:2], e.v[1], e.v[0]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_raw();
        test_issue_retire_same();
        test_two_src();
        test_overflow();
        test_underflow_flush();
        test_deadlock_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
